// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, drives a single-beat instruction bus and the IF register.
// Optional 1-entry skid buffer for acks that land during a stall: define IF_SKID_BUF_EN.
module if_stage #(
  parameter int unsigned       ADDR_W   = 30,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] NOP_INSN = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rd_data,
  output logic              busy,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_en
);

`ifdef IF_SKID_BUF_EN
  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HELD  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   if_pc_q, if_pc_d;
  logic [DATA_W-1:0]   if_insn_q, if_insn_d;
  logic                if_en_q, if_en_d;
  logic [ADDR_W-1:0]   pc_inc;
  logic                ack_ok;

`ifdef IF_SKID_BUF_EN
  logic [DATA_W-1:0]   skid_q, skid_d;
`endif

  assign bus_req  = (state_q == S_FETCH);
  assign bus_addr = pc_q;
  assign busy     = bus_req & ~bus_ack;

  // An ack only counts against a live request; late acks in S_BOOT/S_HELD are ignored.
  assign ack_ok   = bus_req & bus_ack;
  assign pc_inc   = pc_q + ADDR_W'(1);

  assign if_pc    = if_pc_q;
  assign if_insn  = if_insn_q;
  assign if_en    = if_en_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    if_pc_d   = if_pc_q;
    if_insn_d = if_insn_q;
    if_en_d   = if_en_q;
`ifdef IF_SKID_BUF_EN
    skid_d    = skid_q;
`endif

    if (flush) begin
      // Leaving S_HELD is what empties the skid; if_pc deliberately holds.
      pc_d      = new_pc;
      if_en_d   = 1'b0;
      if_insn_d = NOP_INSN;
      state_d   = S_FETCH;
    end else begin
      if (state_q == S_BOOT) begin
        state_d = S_FETCH;
      end

      if (stall) begin
`ifdef IF_SKID_BUF_EN
        if (ack_ok) begin
          skid_d  = bus_rd_data;
          pc_d    = pc_inc;
          state_d = S_HELD;
        end
`endif
      end
`ifdef IF_SKID_BUF_EN
      else if (state_q == S_HELD) begin
        state_d = S_FETCH;
        if (br_taken) begin
          pc_d      = br_addr;
          if_en_d   = 1'b0;
          if_insn_d = NOP_INSN;
        end else begin
          // pc already advanced past the parked word, so it equals captured address + 1.
          if_pc_d   = pc_q;
          if_insn_d = skid_q;
          if_en_d   = 1'b1;
        end
      end
`endif
      else if (br_taken) begin
        pc_d      = br_addr;
        if_en_d   = 1'b0;
        if_insn_d = NOP_INSN;
      end else if (ack_ok) begin
        if_pc_d   = pc_inc;
        if_insn_d = bus_rd_data;
        if_en_d   = 1'b1;
        pc_d      = pc_inc;
      end else begin
        if_en_d   = 1'b0;
        if_insn_d = NOP_INSN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_PC;
      if_pc_q   <= '0;
      if_insn_q <= NOP_INSN;
      if_en_q   <= 1'b0;
`ifdef IF_SKID_BUF_EN
      skid_q    <= NOP_INSN;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      if_pc_q   <= if_pc_d;
      if_insn_q <= if_insn_d;
      if_en_q   <= if_en_d;
`ifdef IF_SKID_BUF_EN
      skid_q    <= skid_d;
`endif
    end
  end

  // A waiting request keeps its address unless flush or a branch aborts it.
  a_addr_stable: assert property (@(posedge clk) disable iff (rst)
    (bus_req && !bus_ack && !flush && !br_taken) |=> $stable(bus_addr));

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model of the fetch rules.
module tb_if_stage;

  localparam int unsigned AW  = 30;
  localparam int unsigned DW  = 32;
  localparam logic [AW-1:0] RST_PC = '0;
  localparam logic [DW-1:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst, stall, flush, br_taken, bus_ack;
  logic [AW-1:0] new_pc, br_addr;
  logic [DW-1:0] bus_rd_data;
  logic          bus_req, busy, if_en;
  logic [AW-1:0] bus_addr, if_pc;
  logic [DW-1:0] if_insn;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Behavioural model state: phase 0 = boot, 1 = fetching, 2 = word parked.
  logic [AW-1:0] m_pc, m_if_pc, m_skid_pc;
  logic [DW-1:0] m_if_insn, m_skid;
  logic          m_if_en;
  int            m_phase;

  if_stage #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .RESET_PC(RST_PC),
    .NOP_INSN(NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .new_pc     (new_pc),
    .br_taken   (br_taken),
    .br_addr    (br_addr),
    .bus_req    (bus_req),
    .bus_addr   (bus_addr),
    .bus_ack    (bus_ack),
    .bus_rd_data(bus_rd_data),
    .busy       (busy),
    .if_pc      (if_pc),
    .if_insn    (if_insn),
    .if_en      (if_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) == 0) return {AW{1'b1}} - AW'($urandom_range(0, 2));
    return r[AW-1:0];
  endfunction

  task automatic bubble();
    m_if_en   = 1'b0;
    m_if_insn = NOP;
  endtask

  // One clock edge of the fetch rules, in priority order rst > flush > stall > br > ack.
  task automatic model_step();
    logic got;
    if (rst) begin
      m_pc = RST_PC; m_if_pc = '0; m_if_insn = NOP; m_if_en = 1'b0; m_phase = 0;
    end else if (flush) begin
      m_pc = new_pc; bubble(); m_phase = 1;
    end else begin
      got = (m_phase == 1) && bus_ack;
      if (stall) begin
`ifdef IF_SKID_BUF_EN
        if (got) begin
          m_skid = bus_rd_data; m_skid_pc = m_pc; m_pc = m_pc + AW'(1); m_phase = 2;
        end
`endif
        if (m_phase == 0) m_phase = 1;
      end else if (m_phase == 2) begin
        if (br_taken) begin
          m_pc = br_addr; bubble();
        end else begin
          m_if_pc = m_skid_pc + AW'(1); m_if_insn = m_skid; m_if_en = 1'b1;
        end
        m_phase = 1;
      end else begin
        if (br_taken) begin
          m_pc = br_addr; bubble();
        end else if (got) begin
          m_if_insn = bus_rd_data; m_if_en = 1'b1;
          m_pc = m_pc + AW'(1); m_if_pc = m_pc;
        end else begin
          bubble();
        end
        m_phase = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; bus_ack = 1'b0;
    new_pc = '0; br_addr = '0; bus_rd_data = '0;
  endtask

  task automatic redirect(input logic [AW-1:0] a);
    br_taken = 1'b1; br_addr = a; bus_ack = 1'b0;
    tick();
    br_taken = 1'b0;
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_bus_req", 32'(bus_req), 32'(m_phase == 1));
      chk("m_bus_addr", 32'(bus_addr), 32'(m_pc));
      chk("m_busy", 32'(busy), 32'((m_phase == 1) && !bus_ack));
      chk("m_if_pc", 32'(if_pc), 32'(m_if_pc));
      chk("m_if_insn", if_insn, m_if_insn);
      chk("m_if_en", 32'(if_en), 32'(m_if_en));
    end
  end

  initial begin
    set_idle();
    rst = 1'b1;
    tick();
    tick();
    cmp_en = 1'b1;
    rst = 1'b0;
    // Boot cycle: no request yet.
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_if_en", 32'(if_en), 32'd0);
    chk("rst_if_insn", if_insn, NOP);
    chk("rst_if_pc", 32'(if_pc), 32'd0);
    tick();
    chk("boot_bus_req", 32'(bus_req), 32'd1);
    chk("boot_bus_addr", 32'(bus_addr), 32'd0);

    // Zero-wait fetches.
    bus_ack = 1'b1; bus_rd_data = 32'h1111_1111;
    tick();
    chk("zw1_insn", if_insn, 32'h1111_1111);
    chk("zw1_pc", 32'(if_pc), 32'd1);
    chk("zw1_en", 32'(if_en), 32'd1);
    chk("zw1_addr", 32'(bus_addr), 32'd1);
    bus_rd_data = 32'h2222_2222;
    tick();
    chk("zw2_insn", if_insn, 32'h2222_2222);
    chk("zw2_pc", 32'(if_pc), 32'd2);
    chk("zw2_en", 32'(if_en), 32'd1);
    bus_ack = 1'b0;

    // Two wait states at 0x10.
    redirect(AW'(32'h10));
    #1 chk("ws_busy0", 32'(busy), 32'd1);
    tick();
    chk("ws_en1", 32'(if_en), 32'd0);
    chk("ws_busy1", 32'(busy), 32'd1);
    tick();
    chk("ws_en2", 32'(if_en), 32'd0);
    bus_ack = 1'b1; bus_rd_data = 32'hA5A5_0010;
    #1 chk("ws_busy_ack", 32'(busy), 32'd0);
    tick();
    chk("ws_insn", if_insn, 32'hA5A5_0010);
    chk("ws_pc", 32'(if_pc), 32'h11);
    chk("ws_en", 32'(if_en), 32'd1);
    bus_ack = 1'b0;

    // Branch squashes the same-cycle ack.
    redirect(AW'(32'h5));
    br_taken = 1'b1; br_addr = AW'(32'h40); bus_ack = 1'b1; bus_rd_data = 32'hDEAD_BEEF;
    tick();
    br_taken = 1'b0; bus_ack = 1'b0;
    chk("br_en", 32'(if_en), 32'd0);
    chk("br_insn", if_insn, NOP);
    chk("br_addr", 32'(bus_addr), 32'h40);

    // Flush wins over stall with a request outstanding.
    bus_ack = 1'b1; bus_rd_data = 32'h1234_5678;
    tick();
    bus_ack = 1'b0; stall = 1'b1; flush = 1'b1; new_pc = AW'(32'h100);
    tick();
    stall = 1'b0; flush = 1'b0;
    chk("fl_en", 32'(if_en), 32'd0);
    chk("fl_insn", if_insn, NOP);
    chk("fl_if_pc", 32'(if_pc), 32'h41);
    chk("fl_addr", 32'(bus_addr), 32'h100);

    // Ack during a 3-cycle stall at pc=8.
    redirect(AW'(32'h8));
    stall = 1'b1; bus_ack = 1'b1; bus_rd_data = 32'hCAFE_0001;
    tick();
    bus_ack = 1'b0;
`ifdef IF_SKID_BUF_EN
    chk("sk_req1", 32'(bus_req), 32'd0);
    tick();
    chk("sk_req2", 32'(bus_req), 32'd0);
    tick();
    chk("sk_req3", 32'(bus_req), 32'd0);
    stall = 1'b0;
    tick();
    chk("sk_insn", if_insn, 32'hCAFE_0001);
    chk("sk_pc", 32'(if_pc), 32'd9);
    chk("sk_en", 32'(if_en), 32'd1);
    chk("sk_addr", 32'(bus_addr), 32'd9);
    chk("sk_req", 32'(bus_req), 32'd1);
`else
    chk("ns_req1", 32'(bus_req), 32'd1);
    chk("ns_addr1", 32'(bus_addr), 32'd8);
    tick();
    tick();
    stall = 1'b0;
    tick();
    chk("ns_en", 32'(if_en), 32'd0);
    chk("ns_addr", 32'(bus_addr), 32'd8);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("ns_insn", if_insn, 32'hCAFE_0001);
    chk("ns_pc", 32'(if_pc), 32'd9);
    chk("ns_en", 32'(if_en), 32'd1);
`endif

    // PC wrap.
    redirect({AW{1'b1}});
    bus_ack = 1'b1; bus_rd_data = 32'h0BAD_F00D;
    tick();
    bus_ack = 1'b0;
    chk("wr_if_pc", 32'(if_pc), 32'd0);
    chk("wr_addr", 32'(bus_addr), 32'd0);
    chk("wr_insn", if_insn, 32'h0BAD_F00D);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      flush       = ($urandom_range(0, 19) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      br_taken    = ($urandom_range(0, 9) == 0);
      br_addr     = rand_addr();
      new_pc      = rand_addr();
      bus_ack     = bus_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
      bus_rd_data = $urandom;
      tick();
    end
    set_idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage.
- Owns the program counter and drives a single-beat instruction bus master.
- Presents the fetched word to id_stage through the IF pipeline register (if_pc, if_insn, if_en).
- Consumes branch redirects from id_stage and stall/flush/new_pc from pipeline control; reports bus wait as busy.

Parameters:
- ADDR_W, 30, word-address width (matches `WordAddr).
- DATA_W, 32, instruction width (matches `WordData).
- RESET_PC, 0, word address fetched first after reset.
- NOP_INSN, 32'h0, encoding loaded into if_insn for bubbles.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- stall  input  1  hold PC and IF register
- flush  input  1  discard fetch, redirect to new_pc
- new_pc  input  ADDR_W  redirect target (exception/return)
- br_taken  input  1  branch redirect from id_stage
- br_addr  input  ADDR_W  branch target from id_stage
- bus_req  output  1  fetch request
- bus_addr  output  ADDR_W  fetch word address
- bus_ack  input  1  read data valid this cycle
- bus_rd_data  input  DATA_W  instruction word
- busy  output  1  request outstanding without ack (to pipeline control)
- if_pc  output  ADDR_W  fetch address + 1 (next sequential word)
- if_insn  output  DATA_W  fetched instruction
- if_en  output  1  if_insn valid

Behaviour:
- One clock (clk); reset rst is synchronous, active-high.
- Reset values: pc=RESET_PC, if_pc=0, if_insn=NOP_INSN, if_en=0, bus_req=0, state=S_BOOT, skid empty.
- Outputs:
  - bus_addr = pc, combinational.
  - bus_req = 1 in S_FETCH, else 0.
  - busy = bus_req & ~bus_ack.
- FSM:
  - S_BOOT: one cycle after reset, no request; -> S_FETCH.
  - S_FETCH: request at pc every cycle until ack.
  - S_HELD (only with IF_SKID_BUF_EN): word parked in skid, bus_req=0.
- Per-cycle priority: rst > flush > stall > br_taken > ack > no-ack.
  - flush:
    - pc<=new_pc; if_en<=0; if_insn<=NOP_INSN; if_pc holds.
    - Any same-cycle ack data discarded; skid cleared; state<=S_FETCH.
    - Flush is honoured even when stall=1.
  - stall (no flush):
    - pc, if_pc, if_insn, if_en hold; br_taken ignored (id_stage re-asserts).
    - Ack data handled per Optional Feature.
  - br_taken (no stall):
    - pc<=br_addr; IF register loads bubble (if_en=0, if_insn=NOP_INSN).
    - Same-cycle ack data squashed.
  - ack, no stall:
    - if_pc<=pc+1; if_insn<=bus_rd_data; if_en<=1; pc<=pc+1.
    - Next request issues the following cycle (sustained 1 insn/cycle on zero-wait bus).
  - no ack, no stall: IF register loads bubble (if_en=0); pc holds; bus_req stays 1.
- pc+1 wraps modulo 2^ADDR_W (all-ones -> 0), no flag.
- bus_addr must not change while bus_req=1 and no ack, except on flush/br_taken (bus tolerates abort).
- Reset mid-request: bus_req drops the next cycle; late ack ignored in S_BOOT.

Optional Feature:
- Macro: IF_SKID_BUF_EN.
- Defined:
  - Ack during stall captures bus_rd_data into a 1-entry skid; pc<=pc+1; state<=S_HELD; bus_req=0.
  - When stall drops: IF register loads from skid with if_pc = captured address+1, if_en=1, zero bus cycles; state<=S_FETCH.
  - br_taken on the release cycle squashes the skid word instead.
  - Flush empties the skid.
- Undefined:
  - Ack during stall is dropped; pc unchanged; bus_req stays 1, so the same address is refetched after stall releases.
  - No S_HELD state.

Test Plan:
- Reset -> bus_req=0 one cycle, then bus_addr=RESET_PC; zero-wait ack of 0x11111111,0x22222222 -> if_insn follows one cycle later, if_pc=1,2, if_en=1 both cycles.
- Two-wait-state bus at pc=0x10 -> busy=1 two cycles, if_en=0 bubbles, then if_insn=data, if_pc=0x11.
- br_taken=1, br_addr=0x40 with ack of 0xDEADBEEF at pc=5 -> if_en=0, next bus_addr=0x40, 0xDEADBEEF never seen.
- flush=1, new_pc=0x100 while stall=1 and a request is outstanding -> if_en=0, if_insn=NOP_INSN, next bus_addr=0x100.
- Stall 3 cycles with ack of 0xCAFE0001 at pc=8, IF_SKID_BUF_EN defined -> bus_req=0 during stall; on release if_insn=0xCAFE0001, if_pc=9, next bus_addr=9.
- Same as above without the macro -> bus re-requests address 8 after release; if_insn=0xCAFE0001 one ack later.
- pc=0x3FFFFFFF ack -> if_pc=0, next bus_addr=0.
